// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction-fetch initiator for the instruction ROM. Owns the PC, drives the
//   ROM chip-enable and byte address, and captures the combinationally returned
//   word into the IF/ID pipeline register. Handles IF/ID stalls, branch
//   redirects (with a delay slot, and deferral across IF stalls) and flushes.
//
// Ports
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   o_ce, o_addr        ROM chip enable and byte address (o_addr == pc)
//   i_inst              ROM read data, valid in the same cycle as o_addr
//   i_stall_if          hold the PC
//   i_stall_id          hold the IF/ID register
//   i_branch(_addr)     one-cycle branch/jump request and its target
//   i_flush(_addr)      flush request and restart address (beats everything)
//   o_id_pc/inst/valid  IF/ID register contents (inst 0 = bubble)
//   o_id_adel           IF/ID word was fetched from a misaligned PC
// -----------------------------------------------------------------------------
module inst_fetch #(
   parameter int                 ADDR_W   = 32,
   parameter int                 DATA_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   output logic              o_ce,
   output logic [ADDR_W-1:0] o_addr,
   input  logic [DATA_W-1:0] i_inst,
   input  logic              i_stall_if,
   input  logic              i_stall_id,
   input  logic              i_branch,
   input  logic [ADDR_W-1:0] i_branch_addr,
   input  logic              i_flush,
   input  logic [ADDR_W-1:0] i_flush_addr,
   output logic [ADDR_W-1:0] o_id_pc,
   output logic [DATA_W-1:0] o_id_inst,
   output logic              o_id_valid,
   output logic              o_id_adel
);

   logic              ce_reg;
   logic [ADDR_W-1:0] pc_reg,       pc_next;
   logic [ADDR_W-1:0] pend_reg,     pend_next;
   logic              pend_vld_reg, pend_vld_next;
   logic [ADDR_W-1:0] id_pc_reg,    id_pc_next;
   logic [DATA_W-1:0] id_inst_reg,  id_inst_next;
   logic              id_valid_reg, id_valid_next;
   logic              id_adel_reg,  id_adel_next;
   logic              misaligned;

   assign misaligned = |pc_reg[1:0];

   // PC / pending-branch next state. Nothing moves until the ROM is enabled.
   always_comb begin
      pc_next       = pc_reg;
      pend_next     = pend_reg;
      pend_vld_next = pend_vld_reg;
      if (ce_reg) begin
         if (i_flush) begin
            pc_next       = i_flush_addr;
            pend_vld_next = 1'b0;
         end else if (i_stall_if) begin
            // PC is frozen, so remember the branch; a newer one replaces it.
            if (i_branch) begin
               pend_next     = i_branch_addr;
               pend_vld_next = 1'b1;
            end
         end else if (i_branch) begin
            pc_next       = i_branch_addr;
            pend_vld_next = 1'b0;
         end else if (pend_vld_reg) begin
            pc_next       = pend_reg;
            pend_vld_next = 1'b0;
         end else begin
            pc_next = pc_reg + ADDR_W'(4);   // wraps naturally at 2^ADDR_W
         end
      end
   end

   // IF/ID register next state. The word fetched while a branch is requested
   // is captured normally: that is the delay slot.
   always_comb begin
      id_pc_next    = id_pc_reg;
      id_inst_next  = id_inst_reg;
      id_valid_next = id_valid_reg;
      id_adel_next  = id_adel_reg;
      if (i_flush || (!i_stall_id && (i_stall_if || !ce_reg))) begin
         id_pc_next    = '0;
         id_inst_next  = '0;
         id_valid_next = 1'b0;
         id_adel_next  = 1'b0;
      end else if (!i_stall_id) begin
         id_pc_next    = pc_reg;
         // A misaligned fetch still completes, but its data is suppressed.
         id_inst_next  = misaligned ? '0 : i_inst;
         id_valid_next = 1'b1;
         id_adel_next  = misaligned;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ce_reg       <= 1'b0;
         pc_reg       <= RESET_PC;
         pend_reg     <= '0;
         pend_vld_reg <= 1'b0;
         id_pc_reg    <= '0;
         id_inst_reg  <= '0;
         id_valid_reg <= 1'b0;
         id_adel_reg  <= 1'b0;
      end else begin
         ce_reg       <= 1'b1;
         pc_reg       <= pc_next;
         pend_reg     <= pend_next;
         pend_vld_reg <= pend_vld_next;
         id_pc_reg    <= id_pc_next;
         id_inst_reg  <= id_inst_next;
         id_valid_reg <= id_valid_next;
         id_adel_reg  <= id_adel_next;
      end
   end

   assign o_ce       = ce_reg;
   assign o_addr     = pc_reg;
   assign o_id_pc    = id_pc_reg;
   assign o_id_inst  = id_inst_reg;
   assign o_id_valid = id_valid_reg;
   assign o_id_adel  = id_adel_reg;

endmodule
